// File: rtl/branch_target_predictor_if.sv
// rtl/branch_target_predictor_if.sv - lookup, update and statistics bundle for the branch target predictor
interface branch_target_predictor_if;
    logic [31:0] LookupPCF;
    logic        HitF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic        UpdateValidD;
    logic [31:0] UpdatePCD;
    logic        UpdateTakenD;
    logic [31:0] UpdateTargetD;
    logic        UpdatePredD;
    logic        FlushTable;
    logic        MispredictD;
    logic [31:0] UpdateCount;
    logic [31:0] MispredCount;

    modport master (
        output LookupPCF, UpdateValidD, UpdatePCD, UpdateTakenD, UpdateTargetD,
               UpdatePredD, FlushTable,
        input  HitF, PredTakenF, PredTargetF, MispredictD, UpdateCount, MispredCount
    );

    modport slave (
        input  LookupPCF, UpdateValidD, UpdatePCD, UpdateTakenD, UpdateTargetD,
               UpdatePredD, FlushTable,
        output HitF, PredTakenF, PredTargetF, MispredictD, UpdateCount, MispredCount
    );
endinterface

// File: rtl/branch_target_predictor.sv
// rtl/branch_target_predictor.sv - direct-mapped tagged BTB with saturating direction counters
module branch_target_predictor #(
    parameter int ENTRIES = 64,
    parameter int TAG_W   = 8,
    parameter int CTR_W   = 2
) (
    input  logic                       Clock,
    input  logic                       Reset,
    branch_target_predictor_if.slave   bp
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(1) << (CTR_W - 1);
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_WEAK_T - CTR_W'(1);
    localparam logic [CTR_W-1:0] CTR_MAX     = '1;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [CTR_W-1:0] ctr_q    [ENTRIES];

    logic [31:0] upd_cnt_q;
    logic [31:0] mis_cnt_q;

    logic [IDX_W-1:0] lk_idx;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [TAG_W-1:0] up_tag;
    logic             lk_hit;
    logic             lk_taken;
    logic             up_hit;
    logic             mispredict;

    assign lk_idx = bp.LookupPCF[IDX_W+1:2];
    assign lk_tag = bp.LookupPCF[IDX_W+TAG_W+1:IDX_W+2];
    assign up_idx = bp.UpdatePCD[IDX_W+1:2];
    assign up_tag = bp.UpdatePCD[IDX_W+TAG_W+1:IDX_W+2];

    // Lookup reads registered state only, so a same-cycle update is not forwarded.
    assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_taken = lk_hit && ctr_q[lk_idx][CTR_W-1];
    assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    assign mispredict = bp.UpdateValidD && (bp.UpdatePredD != bp.UpdateTakenD);

    assign bp.HitF         = lk_hit;
    assign bp.PredTakenF   = lk_taken;
    assign bp.PredTargetF  = lk_taken ? target_q[lk_idx] : bp.LookupPCF + 32'd4;
    assign bp.MispredictD  = mispredict;
    assign bp.UpdateCount  = upd_cnt_q;
    assign bp.MispredCount = mis_cnt_q;

    logic unused_pc_bits;
    assign unused_pc_bits = ^{bp.LookupPCF[1:0], bp.LookupPCF[31:IDX_W+TAG_W+2],
                              bp.UpdatePCD[1:0], bp.UpdatePCD[31:IDX_W+TAG_W+2]};

    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= CTR_WEAK_NT;
            end
        end else if (bp.FlushTable) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else if (bp.UpdateValidD) begin
            if (up_hit) begin
                if (bp.UpdateTakenD) begin
                    if (ctr_q[up_idx] != CTR_MAX) begin
                        ctr_q[up_idx] <= ctr_q[up_idx] + CTR_W'(1);
                    end
                    target_q[up_idx] <= bp.UpdateTargetD;
                end else if (ctr_q[up_idx] != '0) begin
                    ctr_q[up_idx] <= ctr_q[up_idx] - CTR_W'(1);
                end
            end else if (bp.UpdateTakenD) begin
                // Taken miss evicts whatever aliases to this index.
                valid_q[up_idx]  <= 1'b1;
                tag_q[up_idx]    <= up_tag;
                target_q[up_idx] <= bp.UpdateTargetD;
                ctr_q[up_idx]    <= CTR_WEAK_T;
            end
        end
    end

    // Statistics keep counting through a flush; only reset clears them.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            upd_cnt_q <= '0;
            mis_cnt_q <= '0;
        end else begin
            if (bp.UpdateValidD && (upd_cnt_q != 32'hFFFF_FFFF)) begin
                upd_cnt_q <= upd_cnt_q + 32'd1;
            end
            if (mispredict && (mis_cnt_q != 32'hFFFF_FFFF)) begin
                mis_cnt_q <= mis_cnt_q + 32'd1;
            end
        end
    end
endmodule
